// File: rtl/mb_alu_pkg.sv
// rtl/mb_alu_pkg.sv - op encodings, ALU commands and FSM states for mb_alu_seq
package mb_alu_pkg;

    localparam int LEN_W = 3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LSH = 2'b01;
    localparam logic [1:0] OP_RSH = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_LSH = 4'b0001;
    localparam logic [3:0] CMD_RSH = 4'b0010;
    localparam logic [3:0] CMD_MOV = 4'b0011;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mb_alu_seq.sv
// rtl/mb_alu_seq.sv - multi-byte add/shift sequencer driving an 8-bit ALU
//
// Ports: clk/reset (sync, active-high); start/op/len/cin/base_a/base_b/base_d
// request; busy/done/err/cout/zero status; mem_addr/mem_rd_data/mem_wr_en/
// mem_wr_data data-memory port; alu_cmd/alu_ina/alu_inb/alu_sc_i/alu_rslt/
// alu_sc_o ALU port. Each byte takes RD_A, RD_B, EXEC (3 cycles).
module mb_alu_seq
    import mb_alu_pkg::*;
#(
    parameter int MAX_BYTES = 4,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [2:0]    len,
    input  logic          cin,
    input  logic [AW-1:0] base_a,
    input  logic [AW-1:0] base_b,
    input  logic [AW-1:0] base_d,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          cout,
    output logic          zero,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [3:0]    alu_cmd,
    output logic [7:0]    alu_ina,
    output logic [7:0]    alu_inb,
    output logic          alu_sc_i,
    input  logic [7:0]    alu_rslt,
    input  logic          alu_sc_o
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [AW-1:0]    base_a_q, base_a_d;
    logic [AW-1:0]    base_b_q, base_b_d;
    logic [AW-1:0]    base_d_q, base_d_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             bad_req;
    logic             last_byte;
    logic [AW-1:0]    idx_ext;

    assign bad_req   = (op == OP_RSV) || (len == '0) || (len > MAX_LEN);
    // Right shift walks MSB first, so its last byte is index 0.
    assign last_byte = (op_q == OP_RSH) ? (idx_q == '0) : (idx_q == len_q - 1'b1);
    assign idx_ext   = AW'(idx_q);

    // Status flags hold their last result until the next accepted start.
    assign cout = carry_q;
    assign zero = zero_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        len_d       = len_q;
        idx_d       = idx_q;
        base_a_d    = base_a_q;
        base_b_d    = base_b_q;
        base_d_d    = base_d_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        err_d       = err_q;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        alu_cmd     = CMD_MOV;
        alu_ina     = 8'h00;
        alu_inb     = 8'h00;
        alu_sc_i    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    len_d    = len;
                    base_a_d = base_a;
                    base_b_d = base_b;
                    base_d_d = base_d;
                    carry_d  = cin;
                    zero_d   = 1'b1;
                    err_d    = bad_req;
                    idx_d    = (op == OP_RSH) ? len - 1'b1 : '0;
                    state_d  = bad_req ? DONE : RD_A;
                end
            end
            RD_A: begin
                busy     = 1'b1;
                mem_addr = base_a_q + idx_ext;
                a_d      = mem_rd_data;
                state_d  = RD_B;
            end
            RD_B: begin
                // Taken for shifts too so every byte costs three cycles.
                busy     = 1'b1;
                mem_addr = base_b_q + idx_ext;
                b_d      = mem_rd_data;
                state_d  = EXEC;
            end
            EXEC: begin
                busy = 1'b1;
                unique case (op_q)
                    OP_LSH:  alu_cmd = CMD_LSH;
                    OP_RSH:  alu_cmd = CMD_RSH;
                    default: alu_cmd = CMD_ADD;
                endcase
                alu_ina     = a_q;
                alu_inb     = b_q;
                alu_sc_i    = carry_q;
                mem_addr    = base_d_q + idx_ext;
                mem_wr_en   = 1'b1;
                mem_wr_data = alu_rslt;
                carry_d     = alu_sc_o;
                zero_d      = zero_q & (alu_rslt == 8'h00);
                idx_d       = (op_q == OP_RSH) ? idx_q - 1'b1 : idx_q + 1'b1;
                state_d     = last_byte ? DONE : RD_A;
            end
            DONE: begin
                done    = 1'b1;
                err     = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            len_q    <= '0;
            idx_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            base_d_q <= '0;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            base_a_q <= base_a_d;
            base_b_q <= base_b_d;
            base_d_q <= base_d_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_mb_alu_seq.sv
// tb/tb_mb_alu_seq.sv - self-checking bench for mb_alu_seq with ALU and memory models
module tb_mb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [2:0] len;
    logic       cin;
    logic [7:0] base_a, base_b, base_d;
    logic       busy, done, err, cout, zero;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
    logic       mem_wr_en;
    logic [3:0] alu_cmd;
    logic [7:0] alu_ina, alu_inb, alu_rslt;
    logic       alu_sc_i, alu_sc_o;

    logic [7:0] mem [256];
    int         n_wr;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    mb_alu_seq #(.MAX_BYTES(4), .AW(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .len(len), .cin(cin),
        .base_a(base_a), .base_b(base_b), .base_d(base_d),
        .busy(busy), .done(done), .err(err), .cout(cout), .zero(zero),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
        .alu_cmd(alu_cmd), .alu_ina(alu_ina), .alu_inb(alu_inb),
        .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o)
    );

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            n_wr <= n_wr + 1;
        end
    end

    // Reference 8-bit ALU.
    always_comb begin
        alu_rslt = alu_ina;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            4'b0000: {alu_sc_o, alu_rslt} = {1'b0, alu_ina} + {1'b0, alu_inb} + {8'h00, alu_sc_i};
            4'b0001: {alu_sc_o, alu_rslt} = {alu_ina, alu_sc_i};
            4'b0010: {alu_rslt, alu_sc_o} = {alu_sc_i, alu_ina};
            default: ;
        endcase
    end

    typedef struct {
        logic [1:0]      op;
        logic [2:0]      len;
        logic            cin;
        logic [7:0]      ba, bb, bd;
        logic [3:0][7:0] a, b, exp;
        logic            exp_cout, exp_zero, exp_err;
        int              poke;
    } vec_t;

    vec_t vecs[11];
    vec_t sb_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   cyc, busy_cnt, nb, exp_cyc;
        vec_t e;
        nb = (v.len > 4) ? 4 : int'(v.len);
        for (int i = 0; i < 4; i++) mem[8'(v.bd + 8'(i))] = 8'hAA;
        for (int i = 0; i < nb; i++) begin
            mem[8'(v.ba + 8'(i))] = v.a[i];
            if (v.op == 2'b00) mem[8'(v.bb + 8'(i))] = v.b[i];
        end
        n_wr = 0;
        op = v.op; len = v.len; cin = v.cin;
        base_a = v.ba; base_b = v.bb; base_d = v.bd;
        start = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'b11; len = 3'd0;
        cyc = 1; busy_cnt = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (cyc == v.poke) begin
                start = 1'b1; op = 2'b01; len = 3'd1; base_d = 8'h30;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        e = sb_q.pop_front();
        exp_cyc = e.exp_err ? 1 : 3 * int'(e.len) + 1;
        check($sformatf("v%0d done_cycle", id), cyc, exp_cyc);
        check($sformatf("v%0d busy_cycles", id), busy_cnt, e.exp_err ? 0 : 3 * int'(e.len));
        check($sformatf("v%0d err", id), int'(err), int'(e.exp_err));
        check($sformatf("v%0d busy_at_done", id), int'(busy), 0);
        if (!e.exp_err) begin
            check($sformatf("v%0d cout", id), int'(cout), int'(e.exp_cout));
            check($sformatf("v%0d zero", id), int'(zero), int'(e.exp_zero));
            for (int i = 0; i < int'(e.len); i++)
                check($sformatf("v%0d byte%0d", id, i), int'(mem[8'(e.bd + 8'(i))]), int'(e.exp[i]));
        end
        @(posedge clk); #1;
        check($sformatf("v%0d writes", id), n_wr, e.exp_err ? 0 : int'(e.len));
        check($sformatf("v%0d idle_after", id), int'(busy | done), 0);
        if (!e.exp_err) check($sformatf("v%0d cout_hold", id), int'(cout), int'(e.exp_cout));
    endtask

    function automatic vec_t mk(input logic [1:0] o, input logic [2:0] l, input logic c,
                                input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bd,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] x,
                                input logic co, input logic z, input logic er, input int poke);
        vec_t v;
        v.op = o; v.len = l; v.cin = c; v.ba = ba; v.bb = bb; v.bd = bd;
        v.a = a; v.b = b; v.exp = x;
        v.exp_cout = co; v.exp_zero = z; v.exp_err = er; v.poke = poke;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; start = 1'b0; op = 2'b00; len = 3'd0; cin = 1'b0;
        base_a = 8'h00; base_b = 8'h00; base_d = 8'h00;
        n_wr = 0;

        // bytes packed MSB..LSB as {b3,b2,b1,b0}
        vecs[0]  = mk(2'b00, 3'd2, 1'b0, 8'h10, 8'h20, 8'h30, 32'h000001FF, 32'h00000001, 32'h00000200, 1'b0, 1'b0, 1'b0, -1);
        vecs[1]  = mk(2'b01, 3'd2, 1'b1, 8'h10, 8'h20, 8'h30, 32'h00000180, 32'h0,        32'h00000301, 1'b0, 1'b0, 1'b0, -1);
        vecs[2]  = mk(2'b10, 3'd2, 1'b0, 8'h10, 8'h20, 8'h30, 32'h00000101, 32'h0,        32'h00000080, 1'b1, 1'b0, 1'b0, -1);
        vecs[3]  = mk(2'b00, 3'd1, 1'b0, 8'h10, 8'h20, 8'h30, 32'h00000080, 32'h00000080, 32'h00000000, 1'b1, 1'b1, 1'b0, -1);
        vecs[4]  = mk(2'b11, 3'd2, 1'b0, 8'h10, 8'h20, 8'h30, 32'h00000101, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, -1);
        vecs[5]  = mk(2'b00, 3'd5, 1'b0, 8'h10, 8'h20, 8'h30, 32'h01010101, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, -1);
        vecs[6]  = mk(2'b00, 3'd0, 1'b0, 8'h10, 8'h20, 8'h30, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0, 1'b1, -1);
        vecs[7]  = mk(2'b00, 3'd2, 1'b0, 8'hFF, 8'h20, 8'h30, 32'h00002010, 32'h00000605, 32'h00002615, 1'b0, 1'b0, 1'b0, -1);
        vecs[8]  = mk(2'b00, 3'd4, 1'b1, 8'h40, 8'h50, 8'h40, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0, -1);
        vecs[9]  = mk(2'b10, 3'd4, 1'b1, 8'h60, 8'h20, 8'h70, 32'h02000000, 32'h0,        32'h81000000, 1'b0, 1'b0, 1'b0, -1);
        vecs[10] = mk(2'b00, 3'd2, 1'b0, 8'h10, 8'h20, 8'h30, 32'h000001FF, 32'h00000001, 32'h00000200, 1'b0, 1'b0, 1'b0, 3);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst err", int'(err), 0);
        check("rst cout", int'(cout), 0);
        check("rst zero", int'(zero), 0);
        check("rst wr_en", int'(mem_wr_en), 0);
        check("rst alu_cmd", int'(alu_cmd), 3);
        check("rst mem_addr", int'(mem_addr), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

        // Reset during the second RD_A of a 3-byte add.
        mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h01; mem[8'h22] = 8'h01;
        mem[8'h30] = 8'hAA; mem[8'h31] = 8'hAA; mem[8'h32] = 8'hAA;
        op = 2'b00; len = 3'd3; cin = 1'b0;
        base_a = 8'h10; base_b = 8'h20; base_d = 8'h30;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 4; c++) begin @(posedge clk); #1; end
        check("mid busy_before_rst", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid idle busy", int'(busy), 0);
        check("mid idle wr_en", int'(mem_wr_en), 0);
        check("mid idle done", int'(done), 0);
        reset = 1'b0;
        begin
            int seen_done = 0;
            for (int c = 0; c < 10; c++) begin
                if (done) seen_done++;
                @(posedge clk); #1;
            end
            check("mid no_done", seen_done, 0);
        end
        check("mid byte0", int'(mem[8'h30]), 8'h02);
        check("mid byte1", int'(mem[8'h31]), 8'hAA);
        check("mid byte2", int'(mem[8'h32]), 8'hAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mb_alu_seq.md
Name: mb_alu_seq

Overview:
- Multi-byte arithmetic sequencer: the initiator that drives the 8-bit combinational ALU.
- Executes add, left shift or right shift over 1..MAX_BYTES bytes held in data memory, one byte per ALU pass, and chains the ALU's carry/shift-carry between passes.
- Sits beside the core datapath.
- Owns the ALU command and operand ports while busy; reads operands from and writes results to data memory.

Parameters:
- MAX_BYTES, 4: largest legal operand length in bytes.
- AW, 8: data-memory address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 add, 01 left shift, 10 right shift, 11 reserved
- len  in  3  operand length in bytes
- cin  in  1  carry/shift-in for first byte
- base_a  in  AW  address of byte 0 (LSB) of operand A
- base_b  in  AW  address of byte 0 of operand B (add only)
- base_d  in  AW  address of byte 0 of destination
- busy  out  1  high while the operation runs
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; request rejected
- cout  out  1  final carry/shift-out, valid with done
- zero  out  1  all result bytes zero, valid with done
- mem_addr  out  AW  memory address (combinational read)
- mem_rd_data  in  8  read data for mem_addr, same cycle
- mem_wr_en  out  1  memory write strobe
- mem_wr_data  out  8  write data
- alu_cmd  out  4  ALU command
- alu_ina  out  8  ALU operand A
- alu_inb  out  8  ALU operand B
- alu_sc_i  out  1  ALU carry/shift in
- alu_rslt  in  8  ALU result
- alu_sc_o  in  1  ALU carry/shift out

Behaviour:
- Clock and reset: the block uses one clock, clk. reset is synchronous and active-high.
- Reset values: the FSM enters IDLE. busy, done, err, cout, zero, mem_wr_en are 0. mem_addr, mem_wr_data, alu_ina, alu_inb are 0. alu_cmd is 4'b0011 (move, harmless). alu_sc_i is 0.
- Request capture: in IDLE with start=1, the block latches op, len, cin and the three bases.
  - op=11, len=0 or len>MAX_BYTES: go to DONE; next cycle done=1, err=1. No memory writes occur.
- Byte index: add and left shift run idx = 0..len-1 (LSB first). Right shift runs idx = len-1..0 (MSB first).
- Address arithmetic: base + idx, modulo 2^AW (wraps at the top of memory).
- State RD_A: mem_addr = base_a+idx; latch mem_rd_data into a_reg.
- State RD_B: mem_addr = base_b+idx; latch into b_reg. For shifts this state is still taken and b_reg is ignored, which keeps timing fixed.
- State EXEC: drive the ALU and write the result.
  - alu_cmd = 0000 add / 0001 lsh / 0010 rsh.
  - alu_ina = a_reg; alu_inb = b_reg.
  - alu_sc_i = carry register (initialised from cin).
  - mem_addr = base_d+idx; mem_wr_en = 1; mem_wr_data = alu_rslt.
  - carry register <= alu_sc_o; zero accumulator &= (alu_rslt==0).
  - Advance idx. If this was the last byte go to DONE, else go to RD_A.
- State DONE: done=1 for exactly one cycle; cout = carry register; zero = accumulator; then return to IDLE.
  - cout and zero hold their values until the next start is accepted.
- Timing: start sampled in cycle 0. busy=1 in cycles 1..3*len. done=1 in cycle 3*len+1. Error case: done in cycle 1, busy never asserted.
- start while busy or in DONE is ignored; it is not queued.
- Outside EXEC: mem_wr_en=0, alu_cmd=0011.
- Source and destination may overlap. Each byte is read before its own write, so in-place operation (base_d == base_a) is legal.
- reset mid-operation: the next cycle is IDLE with mem_wr_en=0. Bytes already written stay written. No done pulse is issued.

Decomposition:
- Package mb_alu_pkg holds:
  - op encodings (OP_ADD, OP_LSH, OP_RSH);
  - ALU command constants (CMD_ADD=0000, CMD_LSH=0001, CMD_RSH=0010, CMD_MOV=0011);
  - FSM state enum (IDLE, RD_A, RD_B, EXEC, DONE).
- No sub-module: one FSM plus an index counter and a carry register.
- The bench instantiates the existing ALU and a behavioural memory.

Test Plan:
- Add, len=2, cin=0: mem[10]=FF, mem[11]=01, mem[20]=01, mem[21]=00, base_d=30 -> mem[30]=00, mem[31]=02; cout=0, zero=0; done in cycle 7; busy cycles 1..6.
- Left shift, len=2, cin=1: mem[10]=80, mem[11]=01 -> mem[30]=01, mem[31]=03; cout=0.
- Right shift, len=2, cin=0: mem[10]=01, mem[11]=01 -> byte 1 is processed first. Result mem[31]=00, mem[30]=80; cout=1, zero=0.
- Add, len=1: 80+80 -> mem[30]=00, cout=1, zero=1.
- Error and ignore cases:
  - op=11 -> done=1, err=1 in cycle 1; no write.
  - len=5 -> same response.
  - start pulsed while busy -> no effect on the result.
- Wrap and reset:
  - Add, len=2, base_a=FF -> reads addresses FF then 00.
  - Reset asserted during the second RD_A of a len=3 add -> only mem[base_d] is written; idle next cycle; no done pulse.
